ysyx_25040111_upper_exu: RTL and testbench

YSYX_25040111_UPPER_EXU -- requirements
Module: ysyx_25040111_upper_exu

---
 rtl/ysyx_25040111_upper_exu.sv | 107 ++++++++++
 tb/tb_ysyx_25040111_upper_exu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_upper_exu.sv
// U-type (lui/auipc) execute stage: computes the write-back value and static
// next PC, then buffers results in a small circular FIFO toward the WBU.
module ysyx_25040111_upper_exu #(
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_chos,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_wdata,
  output logic        out_wen,
  output logic [31:0] out_dnpc,
  output logic [15:0] retire_cnt
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  logic [4:0]       rd_q    [BUF_DEPTH];
  logic [31:0]      wdata_q [BUF_DEPTH];
  logic             wen_q   [BUF_DEPTH];
  logic [31:0]      dnpc_q  [BUF_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic [15:0]      retire_q;

  logic        push;
  logic        pop;
  logic [31:0] new_wdata;
  logic [31:0] new_dnpc;
  logic        new_wen;

  // in_ready depends only on occupancy, so a full buffer refuses a push even
  // when the head is popped in the same cycle.
  always_comb begin
    in_ready  = (count < DEPTH_C) && !reset;
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    new_wdata = in_chos ? in_imm : (in_pc + in_imm);
    new_dnpc  = in_pc + 32'd4;
    new_wen   = (in_rd != 5'd0);
  end

  always_comb begin
    out_rd    = '0;
    out_wdata = '0;
    out_wen   = 1'b0;
    out_dnpc  = '0;
    if (out_valid) begin
      out_rd    = rd_q[rptr];
      out_wdata = wdata_q[rptr];
      out_wen   = wen_q[rptr];
      out_dnpc  = dnpc_q[rptr];
    end
  end

  assign retire_cnt = retire_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      retire_q <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        rd_q[i]    <= '0;
        wdata_q[i] <= '0;
        wen_q[i]   <= 1'b0;
        dnpc_q[i]  <= '0;
      end
    end else if (flush) begin
      // Flush wins over a same-cycle push/pop: nothing stored, nothing retired.
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        rd_q[wptr]    <= in_rd;
        wdata_q[wptr] <= new_wdata;
        wen_q[wptr]   <= new_wen;
        dnpc_q[wptr]  <= new_dnpc;
        wptr          <= wptr + 1'b1;
      end
      if (pop) begin
        rptr     <= rptr + 1'b1;
        retire_q <= retire_q + 16'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_upper_exu.sv
// Directed vector bench for the U-type execute stage with BUF_DEPTH = 2.
module tb_ysyx_25040111_upper_exu;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_chos;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_wdata;
  logic        out_wen;
  logic [31:0] out_dnpc;
  logic [15:0] retire_cnt;

  int total = 0;
  int bad   = 0;

  ysyx_25040111_upper_exu #(.BUF_DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_chos    (in_chos),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_wdata  (out_wdata),
    .out_wen    (out_wen),
    .out_dnpc   (out_dnpc),
    .retire_cnt (retire_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ch;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_wen;
    logic [31:0] e_dnpc;
    logic [15:0] e_rc;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic fl, input logic iv, input logic ch,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc,
                       input logic ordy);
    @(negedge clock);
    reset = r; flush = fl; in_valid = iv; in_chos = ch;
    in_rd = rd; in_imm = imm; in_pc = pc; out_ready = ordy;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic irdy, input logic ov, input logic [4:0] rd,
                         input logic [31:0] wd, input logic wen, input logic [31:0] dnpc,
                         input logic [15:0] rc);
    chk({tag, ".in_ready"},   {31'd0, in_ready},   {31'd0, irdy});
    chk({tag, ".out_valid"},  {31'd0, out_valid},  {31'd0, ov});
    chk({tag, ".out_rd"},     {27'd0, out_rd},     {27'd0, rd});
    chk({tag, ".out_wdata"},  out_wdata,           wd);
    chk({tag, ".out_wen"},    {31'd0, out_wen},    {31'd0, wen});
    chk({tag, ".out_dnpc"},   out_dnpc,            dnpc);
    chk({tag, ".retire_cnt"}, {16'd0, retire_cnt}, {16'd0, rc});
  endtask

  function automatic vec_t mk(logic fl, logic iv, logic ch, logic [4:0] rd, logic [31:0] imm,
                              logic [31:0] pc, logic ordy, logic e_irdy, logic e_ov,
                              logic [4:0] e_rd, logic [31:0] e_wd, logic e_wen,
                              logic [31:0] e_dnpc, logic [15:0] e_rc);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ch = ch; v.rd = rd; v.imm = imm; v.pc = pc; v.ordy = ordy;
    v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_rd = e_rd; v.e_wd = e_wd; v.e_wen = e_wen;
    v.e_dnpc = e_dnpc; v.e_rc = e_rc;
    return v;
  endfunction

  initial begin
    // Each row: inputs held across one edge, then expected outputs after that edge.
    //              fl iv ch rd     imm            pc             ordy irdy ov rd     wdata          wen dnpc           rc
    vecs[0]  = mk(0, 1, 1, 5'd5,  32'h12345000, 32'h80000000, 1,   1,   1, 5'd5,  32'h12345000, 1,  32'h80000004, 16'd0);
    vecs[1]  = mk(0, 0, 0, 5'd0,  32'h0,        32'h0,        1,   1,   0, 5'd0,  32'h0,        0,  32'h0,        16'd1);
    vecs[2]  = mk(0, 1, 0, 5'd1,  32'hFFFFF000, 32'h00002000, 0,   1,   1, 5'd1,  32'h00001000, 1,  32'h00002004, 16'd1);
    vecs[3]  = mk(0, 1, 0, 5'd0,  32'h00003000, 32'h10000000, 1,   1,   1, 5'd0,  32'h10003000, 0,  32'h10000004, 16'd2);
    vecs[4]  = mk(0, 0, 0, 5'd0,  32'h0,        32'h0,        1,   1,   0, 5'd0,  32'h0,        0,  32'h0,        16'd3);
    vecs[5]  = mk(0, 1, 1, 5'd7,  32'hAAAAA000, 32'h00000100, 0,   1,   1, 5'd7,  32'hAAAAA000, 1,  32'h00000104, 16'd3);
    vecs[6]  = mk(0, 1, 0, 5'd8,  32'h00001000, 32'h00000200, 0,   0,   1, 5'd7,  32'hAAAAA000, 1,  32'h00000104, 16'd3);
    vecs[7]  = mk(0, 1, 1, 5'd9,  32'h55555000, 32'h00000300, 0,   0,   1, 5'd7,  32'hAAAAA000, 1,  32'h00000104, 16'd3);
    vecs[8]  = mk(0, 1, 1, 5'd9,  32'h55555000, 32'h00000300, 1,   1,   1, 5'd8,  32'h00001200, 1,  32'h00000204, 16'd4);
    vecs[9]  = mk(0, 1, 1, 5'd9,  32'h55555000, 32'h00000300, 1,   1,   1, 5'd9,  32'h55555000, 1,  32'h00000304, 16'd5);
    vecs[10] = mk(0, 0, 0, 5'd0,  32'h0,        32'h0,        1,   1,   0, 5'd0,  32'h0,        0,  32'h0,        16'd6);
    vecs[11] = mk(0, 1, 1, 5'd3,  32'h00011000, 32'h00000400, 0,   1,   1, 5'd3,  32'h00011000, 1,  32'h00000404, 16'd6);
    vecs[12] = mk(0, 1, 1, 5'd4,  32'h00022000, 32'h00000500, 0,   0,   1, 5'd3,  32'h00011000, 1,  32'h00000404, 16'd6);
    vecs[13] = mk(1, 1, 1, 5'd6,  32'h00033000, 32'h00000600, 1,   1,   0, 5'd0,  32'h0,        0,  32'h0,        16'd6);
    vecs[14] = mk(0, 1, 1, 5'd2,  32'h00044000, 32'h00000700, 0,   1,   1, 5'd2,  32'h00044000, 1,  32'h00000704, 16'd6);
    vecs[15] = mk(1, 1, 1, 5'd11, 32'h00066000, 32'h00000800, 1,   1,   0, 5'd0,  32'h0,        0,  32'h0,        16'd6);
    vecs[16] = mk(0, 0, 0, 5'd0,  32'h0,        32'h0,        1,   1,   0, 5'd0,  32'h0,        0,  32'h0,        16'd6);

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_chos = 1'b0;
    in_rd = '0; in_imm = '0; in_pc = '0; out_ready = 1'b0;

    // Reset with pushes offered: ignored, in_ready low.
    drive(1, 0, 1, 1, 5'd5, 32'h1000, 32'h0, 1);
    drive(1, 0, 1, 1, 5'd5, 32'h1000, 32'h0, 1);
    chk_all("in_reset", 0, 0, 5'd0, 32'h0, 0, 32'h0, 16'd0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_reset.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      drive(0, vecs[i].fl, vecs[i].iv, vecs[i].ch, vecs[i].rd, vecs[i].imm, vecs[i].pc, vecs[i].ordy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_rd, vecs[i].e_wd,
              vecs[i].e_wen, vecs[i].e_dnpc, vecs[i].e_rc);
    end

    // Reset mid-stream with a pop requested: everything cleared, no partial pop.
    drive(0, 0, 1, 1, 5'd12, 32'h00077000, 32'h00000900, 0);
    drive(0, 0, 1, 0, 5'd13, 32'h00088000, 32'h00000A00, 0);
    chk_all("two_buffered", 0, 1, 5'd12, 32'h00077000, 1, 32'h00000904, 16'd6);
    drive(1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1);
    chk_all("mid_reset", 0, 0, 5'd0, 32'h0, 0, 32'h0, 16'd0);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1);
    chk_all("after_mid_reset", 1, 0, 5'd0, 32'h0, 0, 32'h0, 16'd0);

    // retire_cnt wrap: one push, then steady push+pop at occupancy 1.
    drive(0, 0, 1, 1, 5'd1, 32'h00001000, 32'h0, 0);
    for (int n = 0; n < 65535; n++) begin
      @(negedge clock);
      out_ready = 1'b1;
      in_pc = 32'(n);
      @(posedge clock);
    end
    #1;
    chk("rc_ffff", {16'd0, retire_cnt}, 32'h0000FFFF);
    chk("rc_ffff.out_valid", {31'd0, out_valid}, 32'd1);
    chk("rc_ffff.out_dnpc", out_dnpc, 32'd65534 + 32'd4);
    drive(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 1);
    chk("rc_wrap", {16'd0, retire_cnt}, 32'h0);
    chk("rc_wrap.out_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
